// File: rtl/data_bus_arbiter.sv
// Two-master, single-slave bus arbiter: round-robin grant, one registered
// transaction in flight, response steering and a slave-stall watchdog.
module data_bus_arbiter #(
  parameter int unsigned TIMEOUT     = 255,
  parameter logic        OWNER_RESET = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,

  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,

  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,

  output logic        s_req_o,
  output logic        s_we_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  input  logic        s_gnt_i,
  input  logic        s_rvalid_i,
  input  logic [31:0] s_rdata_i,

  output logic        busy_o,
  output logic        owner_o
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  // Saturating at TIMEOUT keeps the expiry compare live after a late slave grant.
  localparam logic [CW-1:0] CNT_SAT = (TIMEOUT == 0) ? {CW{1'b1}} : CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next, cnt_inc;
  logic          owner_reg, owner_next;
  logic          last_owner_reg, last_owner_next;
  logic          we_reg, we_next;
  logic [3:0]    be_reg, be_next;
  logic [31:0]   addr_reg, addr_next;
  logic [31:0]   wdata_reg, wdata_next;

  logic          grant;
  logic          sel;
  logic          resp_valid;
  logic          resp_err;
  logic          timeout_hit;

  logic [1:0]    req;
  logic [1:0]    we_in;
  logic [3:0]    be_in    [2];
  logic [31:0]   addr_in  [2];
  logic [31:0]   wdata_in [2];

  logic [1:0]    gnt;
  logic [1:0]    rvalid;
  logic [1:0]    err;
  logic [31:0]   rdata    [2];

  assign req         = {m1_req_i, m0_req_i};
  assign we_in       = {m1_we_i, m0_we_i};
  assign be_in[0]    = m0_be_i;
  assign be_in[1]    = m1_be_i;
  assign addr_in[0]  = m0_addr_i;
  assign addr_in[1]  = m1_addr_i;
  assign wdata_in[0] = m0_wdata_i;
  assign wdata_in[1] = m1_wdata_i;

  assign sel         = (req == 2'b11) ? ~last_owner_reg : req[1];
  assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_SAT);
  assign cnt_inc     = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + CW'(1);

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    we_next         = we_reg;
    be_next         = be_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    grant           = 1'b0;
    resp_valid      = 1'b0;
    resp_err        = 1'b0;

    case (state_reg)
      IDLE: begin
        // Grant is suppressed while reset is held so every output reads 0.
        if ((|req) && rst_n_i) begin
          grant           = 1'b1;
          owner_next      = sel;
          last_owner_next = sel;
          we_next         = we_in[sel];
          be_next         = be_in[sel];
          addr_next       = addr_in[sel];
          wdata_next      = wdata_in[sel];
          cnt_next        = '0;
          state_next      = ADDR;
        end
      end
      ADDR: begin
        cnt_next = cnt_inc;
        if (s_gnt_i) begin
          state_next = RESP;
        end else if (timeout_hit) begin
          resp_valid = 1'b1;
          resp_err   = 1'b1;
          state_next = IDLE;
        end
      end
      RESP: begin
        cnt_next = cnt_inc;
        // A real response on the expiry cycle takes priority over the error.
        if (s_rvalid_i) begin
          resp_valid = 1'b1;
          state_next = IDLE;
        end else if (timeout_hit) begin
          resp_valid = 1'b1;
          resp_err   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      owner_reg      <= 1'b0;
      last_owner_reg <= OWNER_RESET;
      we_reg         <= 1'b0;
      be_reg         <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      we_reg         <= we_next;
      be_reg         <= be_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    assign gnt[gi]    = grant && (sel == 1'(gi));
    assign rvalid[gi] = resp_valid && (owner_reg == 1'(gi));
    assign err[gi]    = rvalid[gi] && resp_err;
    assign rdata[gi]  = (rvalid[gi] && !resp_err) ? s_rdata_i : '0;
  end

  assign m0_gnt_o    = gnt[0];
  assign m0_rvalid_o = rvalid[0];
  assign m0_err_o    = err[0];
  assign m0_rdata_o  = rdata[0];
  assign m1_gnt_o    = gnt[1];
  assign m1_rvalid_o = rvalid[1];
  assign m1_err_o    = err[1];
  assign m1_rdata_o  = rdata[1];

  assign s_req_o   = (state_reg == ADDR);
  assign s_we_o    = we_reg;
  assign s_be_o    = be_reg;
  assign s_addr_o  = addr_reg;
  assign s_wdata_o = wdata_reg;
  assign busy_o    = (state_reg != IDLE);
  assign owner_o   = owner_reg;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: directed scenarios with literal expectations,
// then random traffic, all checked every cycle against a transaction-level model.
module tb_data_bus_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [3:0]  m0_be = '0, m1_be = '0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic        s_gnt = 1'b0, s_rvalid = 1'b0;
  logic [31:0] s_rdata = '0;

  logic        m0_gnt_o, m0_rvalid_o, m0_err_o, m1_gnt_o, m1_rvalid_o, m1_err_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        s_req_o, s_we_o, busy_o, owner_o;
  logic [3:0]  s_be_o;
  logic [31:0] s_addr_o, s_wdata_o;

  int checks = 0;
  int fails  = 0;

  data_bus_arbiter #(.TIMEOUT(TO), .OWNER_RESET(1'b1)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr),
    .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
    .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr),
    .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
    .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_addr_o(s_addr_o),
    .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  always #5 clk = ~clk;

  function automatic logic [141:0] outs();
    return {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o,
            m0_rdata_o, m1_rdata_o, s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o,
            busy_o, owner_o};
  endfunction

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit          md_busy = 0, md_acc = 0, md_owner = 0, md_last = 1;
  int          md_elapsed = 0;
  logic        md_we = 0;
  logic [3:0]  md_be = '0;
  logic [31:0] md_addr = '0, md_wdata = '0;

  logic [1:0]   e_gnt, e_rv, e_err;
  logic [31:0]  e_rd0, e_rd1;
  logic         e_sreq, win, to_hit, done;
  logic [141:0] exp_v;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_cycle", 192'(outs()), 192'(0));
      md_busy = 0; md_acc = 0; md_owner = 0; md_last = 1; md_elapsed = 0;
      md_we = 0; md_be = '0; md_addr = '0; md_wdata = '0;
    end else begin
      e_gnt = '0; e_rv = '0; e_err = '0; e_rd0 = '0; e_rd1 = '0;
      e_sreq = 0; win = 0; done = 0;
      to_hit = (TO != 0) && (md_elapsed >= TO);
      if (!md_busy) begin
        if (m0_req || m1_req) begin
          win = (m0_req && m1_req) ? !md_last : m1_req;
          e_gnt[win] = 1'b1;
        end
      end else if (!md_acc) begin
        e_sreq = 1;
        if (!s_gnt && to_hit) begin
          done = 1; e_rv[md_owner] = 1'b1; e_err[md_owner] = 1'b1;
        end
      end else begin
        if (s_rvalid) begin
          done = 1; e_rv[md_owner] = 1'b1;
          if (md_owner) e_rd1 = s_rdata; else e_rd0 = s_rdata;
        end else if (to_hit) begin
          done = 1; e_rv[md_owner] = 1'b1; e_err[md_owner] = 1'b1;
        end
      end
      exp_v = {e_gnt[0], e_gnt[1], e_rv[0], e_rv[1], e_err[0], e_err[1], e_rd0, e_rd1,
               e_sreq, md_we, md_be, md_addr, md_wdata, md_busy, md_owner};
      chk("cycle_model", 192'(outs()), 192'(exp_v));
      if (done)
        $display("txn m%0d we=%0d addr=%08h err=%0d rdata=%08h", md_owner, md_we,
                 md_addr, e_err[md_owner], md_owner ? e_rd1 : e_rd0);
      if (!md_busy) begin
        if (e_gnt != 2'b00) begin
          md_busy = 1; md_acc = 0; md_elapsed = 0; md_owner = win; md_last = win;
          md_we = win ? m1_we : m0_we;       md_be = win ? m1_be : m0_be;
          md_addr = win ? m1_addr : m0_addr; md_wdata = win ? m1_wdata : m0_wdata;
        end
      end else if (done) begin
        md_busy = 0;
      end else begin
        if (!md_acc && s_gnt) md_acc = 1;
        md_elapsed++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_fields(output logic we, output logic [3:0] be,
                            output logic [31:0] addr, output logic [31:0] wdata);
    we = 1'($urandom_range(0, 1));
    be = 4'($urandom_range(1, 15));
    addr = $urandom;
    wdata = $urandom;
  endtask

  int          ngr, nrv, early;
  logic [3:0]  ord;
  logic        g0, g1;

  initial begin
    #2 chk("reset_outputs", 192'(outs()), 192'(0));
    repeat (2) tick();
    rst_n = 1;

    // Single read, zero-wait slave
    tick();
    m0_req = 1; m0_we = 0; m0_be = 4'hF; m0_addr = 32'h100; s_gnt = 1;
    #1 chk("rd_gnt", 192'({m0_gnt_o, m1_gnt_o}), 192'(2'b10));
    tick(); m0_req = 0;
    #1 chk("rd_sreq", 192'({s_req_o, s_we_o, s_addr_o}), 192'({1'b1, 1'b0, 32'h100}));
    tick(); s_gnt = 0; s_rvalid = 1; s_rdata = 32'hDEADBEEF;
    #1 chk("rd_resp", 192'({m0_rvalid_o, m0_err_o, m0_rdata_o, m1_rvalid_o}),
           192'({1'b1, 1'b0, 32'hDEADBEEF, 1'b0}));
    tick(); s_rvalid = 0; s_rdata = '0;

    // Contention after reset: both hold requests
    rst_n = 0; tick(); rst_n = 1;
    tick();
    m0_req = 1; m0_addr = 32'h10; m1_req = 1; m1_we = 0; m1_be = 4'hF; m1_addr = 32'h20;
    s_gnt = 1; s_rvalid = 1;
    ngr = 0; ord = 4'h0;
    for (int c = 0; c < 20; c++) begin
      if (c != 0) tick();
      s_rdata = $urandom;
      #1;
      if (m0_gnt_o || m1_gnt_o) begin
        if (ngr < 4) ord[ngr] = m1_gnt_o;
        ngr++;
      end
      if (ngr >= 4) break;
    end
    chk("cont_order", 192'({ngr[7:0], ord}), 192'({8'd4, 4'b1010}));
    tick(); m0_req = 0; m1_req = 0;
    repeat (2) tick();
    s_gnt = 0; s_rvalid = 0;

    // Write with slave grant delayed by 3 cycles
    tick();
    m1_req = 1; m1_we = 1; m1_be = 4'b0011; m1_addr = 32'h8000_0000; m1_wdata = 32'h1234;
    #1 chk("wr_gnt", 192'({m0_gnt_o, m1_gnt_o}), 192'(2'b01));
    for (int k = 0; k < 4; k++) begin
      tick();
      m1_req = 0;
      s_gnt = (k == 3);
      #1 chk("wr_fields", 192'({s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o}),
             192'({1'b1, 1'b1, 4'b0011, 32'h8000_0000, 32'h1234}));
    end
    nrv = 0;
    tick(); s_gnt = 0; s_rvalid = 1; s_rdata = 32'h5555AAAA;
    #1 nrv += int'(m1_rvalid_o);
    chk("wr_err", 192'({m1_err_o, m0_rvalid_o}), 192'(0));
    tick(); s_rvalid = 0;
    #1 nrv += int'(m1_rvalid_o);
    tick();
    #1 nrv += int'(m1_rvalid_o);
    chk("wr_rvalid_count", 192'(nrv), 192'(1));

    // Timeout: slave never responds
    tick();
    m0_req = 1; m0_we = 0; m0_addr = 32'h200; s_gnt = 1; s_rdata = 32'hFFFFFFFF;
    early = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      m0_req = 0;
      #1;
      if (k < 5) early += int'(m0_rvalid_o | m1_rvalid_o);
      else chk("to_resp", 192'({m0_rvalid_o, m0_err_o, m0_rdata_o, m1_rvalid_o}),
               192'({1'b1, 1'b1, 32'h0, 1'b0}));
    end
    chk("to_early", 192'(early), 192'(0));
    tick(); s_gnt = 0; s_rvalid = 1; s_rdata = 32'h12345678;
    #1 chk("to_stale", 192'({m0_rvalid_o, m1_rvalid_o, busy_o}), 192'(0));
    tick(); s_rvalid = 0;

    // Response on the exact expiry cycle
    tick();
    m1_req = 1; m1_we = 0; m1_addr = 32'h300; s_gnt = 1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      m1_req = 0;
      if (k == 5) begin s_rvalid = 1; s_rdata = 32'hCAFEF00D; end
      #1;
    end
    chk("tie_resp", 192'({m1_rvalid_o, m1_err_o, m1_rdata_o}), 192'({1'b1, 1'b0, 32'hCAFEF00D}));
    tick(); s_rvalid = 0; s_gnt = 0;

    // Reset while waiting in RESP
    tick();
    m0_req = 1; m0_addr = 32'h400; s_gnt = 1;
    tick(); m0_req = 0;
    tick(); m1_req = 1; m1_addr = 32'h500;
    #1 chk("rst_busy_before", 192'(busy_o), 192'(1));
    rst_n = 0;
    #1 chk("rst_outputs", 192'(outs()), 192'(0));
    tick(); rst_n = 1; m0_req = 1; s_rvalid = 1;
    #1 chk("rst_next_gnt", 192'({m0_gnt_o, m1_gnt_o}), 192'(2'b10));
    tick(); m0_req = 0;
    repeat (2) tick();
    tick(); m1_req = 0;
    repeat (2) tick();
    s_gnt = 0; s_rvalid = 0;

    // Random traffic
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      g0 = m0_gnt_o;
      g1 = m1_gnt_o;
      tick();
      if (!m0_req) begin
        if ($urandom_range(0, 2) == 0) begin
          m0_req = 1; new_fields(m0_we, m0_be, m0_addr, m0_wdata);
        end
      end else if (g0) begin
        if ($urandom_range(0, 1) == 0) new_fields(m0_we, m0_be, m0_addr, m0_wdata);
        else m0_req = 0;
      end
      if (!m1_req) begin
        if ($urandom_range(0, 2) == 0) begin
          m1_req = 1; new_fields(m1_we, m1_be, m1_addr, m1_wdata);
        end
      end else if (g1) begin
        if ($urandom_range(0, 1) == 0) new_fields(m1_we, m1_be, m1_addr, m1_wdata);
        else m1_req = 0;
      end
      s_gnt = ($urandom_range(0, 99) < 55);
      s_rvalid = ($urandom_range(0, 99) < 40);
      s_rdata = $urandom;
    end
    m0_req = 0; m1_req = 0;
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
